// File: rtl/harness_pkg.sv
// Shared types and helpers for the program run-and-check harness.
package harness_pkg;

  typedef enum logic [2:0] {
    StClear,
    StLoad,
    StRun,
    StCheck,
    StDone
  } hstate_t;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd4096;

  // Widest packed table and widest entry tbl_get accepts.
  localparam int unsigned TBL_MAX_W = 1024;
  localparam int unsigned ENT_MAX_W = 32;

  // Returns entry i (each w bits, entry 0 in the LSBs), zero-extended.
  function automatic logic [ENT_MAX_W-1:0] tbl_get(input logic [TBL_MAX_W-1:0] tbl,
                                                   input int unsigned w,
                                                   input int unsigned i);
    logic [TBL_MAX_W-1:0] sh;
    sh      = tbl >> (w * i);
    tbl_get = '0;
    for (int b = 0; b < ENT_MAX_W; b++) begin
      if (b < int'(w)) tbl_get[b] = sh[b];
    end
  endfunction

endpackage

// File: rtl/harness_cmp.sv
// One-entry result comparator with mismatch counter and first-mismatch index latch.
module harness_cmp #(
  parameter int unsigned DW   = 8,
  parameter int unsigned ERRW = 3,
  parameter int unsigned IDXW = 2
) (
  input  logic            i_clk,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [IDXW-1:0] i_idx,
  input  logic [DW-1:0]   i_rd_data,
  input  logic [DW-1:0]   i_exp,
  output logic            o_mismatch,
  output logic [ERRW-1:0] o_err_count,
  output logic [IDXW-1:0] o_first_err_idx
);

  logic [ERRW-1:0] r_err_count;
  logic [IDXW-1:0] r_first_err_idx;

  assign o_mismatch = i_en && (i_rd_data != i_exp);

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_err_count     <= '0;
      r_first_err_idx <= '0;
    end else if (o_mismatch) begin
      if (r_err_count == '0) r_first_err_idx <= i_idx;
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign o_err_count     = r_err_count;
  assign o_first_err_idx = r_first_err_idx;

endmodule

// File: rtl/prog_harness.sv
// Run-and-check harness: clears and preloads data memory, runs the core until halt
// or timeout, then compares result words and reports a sticky verdict.
module prog_harness
  import harness_pkg::*;
#(
  parameter int unsigned               DW        = 8,
  parameter int unsigned               AW        = 8,
  parameter int unsigned               N_LOAD    = 4,
  parameter int unsigned               N_CHECK   = 4,
  parameter logic [N_LOAD*AW-1:0]      LOAD_ADDR = '0,
  parameter logic [N_LOAD*DW-1:0]      LOAD_DATA = '0,
  parameter logic [N_CHECK*AW-1:0]     CHK_ADDR  = '0,
  parameter logic [N_CHECK*DW-1:0]     CHK_DATA  = '0,
  parameter int unsigned               CW        = 16,
  parameter int unsigned               TIMEOUT   = 32'(TIMEOUT_DEFAULT)
) (
  input  logic                         CLK,
  input  logic                         start,
  output logic                         mem_wr_en,
  output logic [AW-1:0]                mem_addr,
  output logic [DW-1:0]                mem_wr_data,
  input  logic [DW-1:0]                mem_rd_data,
  output logic                         dut_start,
  input  logic                         dut_halt,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [$clog2(N_CHECK+1)-1:0] err_count,
  output logic [$clog2(N_CHECK)-1:0]   first_err_idx,
  output logic [CW-1:0]                cycles
);

  localparam int unsigned ERRW = $clog2(N_CHECK + 1);
  localparam int unsigned IDXW = $clog2(N_CHECK);
  // One index counter is shared by the clear sweep and both tables.
  localparam int unsigned IW0  = (AW > $clog2(N_LOAD)) ? AW : $clog2(N_LOAD);
  localparam int unsigned IW   = (IW0 > $clog2(N_CHECK)) ? IW0 : $clog2(N_CHECK);

  localparam logic [IW-1:0] LAST_CLR   = IW'(2 ** AW - 1);
  localparam logic [IW-1:0] LAST_LOAD  = IW'(N_LOAD - 1);
  localparam logic [IW-1:0] LAST_CHK   = IW'(N_CHECK - 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'(TIMEOUT - 1);

  hstate_t         r_state, w_state_d;
  logic [IW-1:0]   r_idx, w_idx_d;
  logic [CW-1:0]   r_cycles;
  logic            r_done, r_pass, r_timeout, r_dut_start;

  logic            w_run_to;
  logic            w_chk_last;
  logic            w_chk_en;
  logic            w_mismatch;
  logic [ERRW-1:0] w_err_count;
  logic [IDXW-1:0] w_first_err_idx;
  logic [AW-1:0]   w_load_addr, w_chk_addr;
  logic [DW-1:0]   w_load_data, w_chk_data;

  assign w_load_addr = AW'(tbl_get(TBL_MAX_W'(LOAD_ADDR), AW, 32'(r_idx)));
  assign w_load_data = DW'(tbl_get(TBL_MAX_W'(LOAD_DATA), DW, 32'(r_idx)));
  assign w_chk_addr  = AW'(tbl_get(TBL_MAX_W'(CHK_ADDR), AW, 32'(r_idx)));
  assign w_chk_data  = DW'(tbl_get(TBL_MAX_W'(CHK_DATA), DW, 32'(r_idx)));

  assign w_run_to   = (r_state == StRun) && !dut_halt && (r_cycles == CYC_LAST);
  assign w_chk_last = (r_state == StCheck) && (r_idx == LAST_CHK);
  assign w_chk_en   = (r_state == StCheck) && !start;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    unique case (r_state)
      StClear: begin
        if (r_idx == LAST_CLR) begin
          w_state_d = StLoad;
          w_idx_d   = '0;
        end else begin
          w_idx_d = r_idx + 1'b1;
        end
      end
      StLoad: begin
        if (r_idx == LAST_LOAD) begin
          w_state_d = StRun;
          w_idx_d   = '0;
        end else begin
          w_idx_d = r_idx + 1'b1;
        end
      end
      StRun: begin
        if (dut_halt)      w_state_d = StCheck;
        else if (w_run_to) w_state_d = StDone;
      end
      StCheck: begin
        if (w_chk_last) begin
          w_state_d = StDone;
          w_idx_d   = '0;
        end else begin
          w_idx_d = r_idx + 1'b1;
        end
      end
      StDone:  w_state_d = StDone;
      default: w_state_d = StClear;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      r_state     <= StClear;
      r_idx       <= '0;
      r_cycles    <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_dut_start <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      if ((r_state == StRun) && !dut_halt && (r_cycles != {CW{1'b1}})) begin
        r_cycles <= r_cycles + 1'b1;
      end
      if ((r_state == StLoad) && (r_idx == LAST_LOAD)) r_dut_start <= 1'b0;
      if (w_run_to) begin
        r_timeout <= 1'b1;
        r_done    <= 1'b1;
      end
      // Verdict must include the mismatch of the final entry, not yet in err_count.
      if (w_chk_last) begin
        r_done <= 1'b1;
        r_pass <= (w_err_count == '0) && !w_mismatch;
      end
    end
  end

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    unique case (r_state)
      StClear: begin
        mem_wr_en = !start;
        mem_addr  = r_idx[AW-1:0];
      end
      StLoad: begin
        mem_wr_en   = !start;
        mem_addr    = w_load_addr;
        mem_wr_data = w_load_data;
      end
      StCheck: mem_addr = w_chk_addr;
      default: mem_addr = '0;
    endcase
  end

  harness_cmp #(
    .DW   (DW),
    .ERRW (ERRW),
    .IDXW (IDXW)
  ) u_cmp (
    .i_clk           (CLK),
    .i_clr           (start),
    .i_en            (w_chk_en),
    .i_idx           (r_idx[IDXW-1:0]),
    .i_rd_data       (mem_rd_data),
    .i_exp           (w_chk_data),
    .o_mismatch      (w_mismatch),
    .o_err_count     (w_err_count),
    .o_first_err_idx (w_first_err_idx)
  );

  assign dut_start     = r_dut_start;
  assign done          = r_done;
  assign pass          = r_pass;
  assign timeout       = r_timeout;
  assign err_count     = w_err_count;
  assign first_err_idx = w_first_err_idx;
  assign cycles        = r_cycles;

endmodule

// File: tb/tb_prog_harness.sv
// Scoreboard bench for prog_harness with a memory model and a stub core.
module tb_prog_harness;

  logic        CLK = 1'b0;
  logic        start;
  logic        mem_wr_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data;
  logic        dut_start;
  logic        dut_halt;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [2:0]  err_count;
  logic [1:0]  first_err_idx;
  logic [15:0] cycles;

  always #5 CLK = ~CLK;

  prog_harness #(
    .DW        (8),
    .AW        (8),
    .N_LOAD    (4),
    .N_CHECK   (4),
    .LOAD_ADDR ({8'd11, 8'd10, 8'd9, 8'd8}),
    .LOAD_DATA ({8'h00, 8'h00, 8'h01, 8'h00}),
    .CHK_ADDR  ({8'd11, 8'd10, 8'd9, 8'd8}),
    .CHK_DATA  ({8'h00, 8'h00, 8'h01, 8'h00}),
    .CW        (16),
    .TIMEOUT   (64)
  ) u_dut (
    .CLK           (CLK),
    .start         (start),
    .mem_wr_en     (mem_wr_en),
    .mem_addr      (mem_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_rd_data   (mem_rd_data),
    .dut_start     (dut_start),
    .dut_halt      (dut_halt),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .cycles        (cycles)
  );

  // Data memory model: async read, sync write, plus bench fill/poke ports.
  logic [7:0] mem [256];
  logic       fill_en = 1'b0;
  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = '0;
  logic [7:0] poke_data = '0;

  always @(posedge CLK) begin
    if (fill_en) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'hFF;
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      if (poke_en) mem[poke_addr] <= poke_data;
    end
  end
  assign mem_rd_data = mem[mem_addr];

  // Stub core: halts stub_k cycles after its start falls.
  int unsigned scnt = 0;
  int unsigned stub_k = 20;
  logic        stub_en = 1'b0;
  logic        halt_force = 1'b0;

  always @(posedge CLK) begin
    if (dut_start) scnt <= 0;
    else if (scnt < 100000) scnt <= scnt + 1;
  end
  assign dut_halt = halt_force | (stub_en && (scnt >= stub_k));

  int unsigned edge_cnt = 0;
  int unsigned ds_cnt = 0;
  always @(posedge CLK) begin
    if (start) begin
      edge_cnt <= 0;
      ds_cnt   <= 0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (dut_start) ds_cnt <= ds_cnt + 1;
    end
  end

  typedef struct packed {
    logic        pass;
    logic        to;
    logic [2:0]  err;
    logic [1:0]  idx;
    logic [15:0] cyc;
    logic [15:0] lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  logic addr_hit = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic p, input logic t, input int e, input int i,
                                  input int c, input int l);
    exp_t x;
    x.pass = p;
    x.to   = t;
    x.err  = 3'(e);
    x.idx  = 2'(i);
    x.cyc  = 16'(c);
    x.lat  = 16'(l);
    return x;
  endfunction

  // Monitor: pops the scoreboard whenever a verdict appears.
  initial begin
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge CLK);
      if (start) addr_hit = 1'b0;
      else if (!dut_start && !done && mem_addr >= 8'd8 && mem_addr <= 8'd11) addr_hit = 1'b1;
      if (done && !done_q) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          e = sb_q.pop_front();
          chk("pass", 32'(pass), 32'(e.pass));
          chk("timeout", 32'(timeout), 32'(e.to));
          chk("err_count", 32'(err_count), 32'(e.err));
          chk("first_err_idx", 32'(first_err_idx), 32'(e.idx));
          chk("cycles", 32'(cycles), 32'(e.cyc));
          chk("latency", edge_cnt, 32'(e.lat));
        end
      end
      done_q = done;
    end
  end

  task automatic begin_run(input exp_t e, input int unsigned k, input logic k_en,
                           input logic fill);
    start   = 1'b1;
    stub_k  = k;
    stub_en = k_en;
    repeat (2) @(negedge CLK);
    if (fill) begin
      fill_en = 1'b1;
      @(negedge CLK);
      fill_en = 1'b0;
    end
    sb_q.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned max);
    int unsigned n = 0;
    while (!done && n < max) begin
      @(negedge CLK);
      n++;
    end
    if (!done) chk("wait_done", 32'(done), 32'(1));
    @(negedge CLK);
  endtask

  task automatic poke_after_release(input logic [7:0] a, input logic [7:0] d);
    int unsigned n = 0;
    while (dut_start && n < 400) begin
      @(negedge CLK);
      n++;
    end
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge CLK);
    poke_en = 1'b0;
  endtask

  initial begin
    int bad;
    int unsigned n;
    start = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_dut_start", 32'(dut_start), 32'(1));
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_pass", 32'(pass), 32'(0));
    chk("rst_timeout", 32'(timeout), 32'(0));
    chk("rst_err_count", 32'(err_count), 32'(0));
    chk("rst_first_err_idx", 32'(first_err_idx), 32'(0));
    chk("rst_cycles", 32'(cycles), 32'(0));

    // Basic pass over a 0xFF-filled memory.
    begin_run(mk_exp(1, 0, 0, 0, 20, 285), 20, 1'b1, 1'b1);
    wait_done(400);
    chk("dut_start_high_cycles", ds_cnt, 32'd260);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      if (mem[a] !== ((a == 9) ? 8'h01 : 8'h00)) bad++;
    end
    chk("clear_coverage_bad_words", 32'(bad), 32'(0));
    repeat (5) @(negedge CLK);
    chk("done_sticky", 32'(done), 32'(1));
    chk("pass_sticky", 32'(pass), 32'(1));
    chk("dut_start_low_in_done", 32'(dut_start), 32'(0));

    // Single mismatch at entry 1.
    begin_run(mk_exp(0, 0, 1, 1, 20, 285), 20, 1'b1, 1'b0);
    poke_after_release(8'd9, 8'h02);
    wait_done(400);

    // Two mismatches, first at entry 2.
    begin_run(mk_exp(0, 0, 2, 2, 20, 285), 20, 1'b1, 1'b0);
    poke_after_release(8'd10, 8'h05);
    poke_addr = 8'd11;
    poke_data = 8'h07;
    poke_en   = 1'b1;
    @(negedge CLK);
    poke_en = 1'b0;
    wait_done(400);

    // Timeout: core never halts.
    begin_run(mk_exp(0, 1, 0, 0, 64, 324), 0, 1'b0, 1'b0);
    wait_done(500);
    chk("timeout_no_check_reads", 32'(addr_hit), 32'(0));

    // Halt in the very first RUN cycle.
    begin_run(mk_exp(1, 0, 0, 0, 0, 265), 0, 1'b1, 1'b0);
    wait_done(400);

    // Abort mid-run at cycles==10, then rerun.
    start   = 1'b1;
    stub_k  = 20;
    stub_en = 1'b1;
    repeat (2) @(negedge CLK);
    start = 1'b0;
    n = 0;
    while (cycles != 16'd10 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_cycles_10", 32'(cycles), 32'd10);
    start = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort_dut_start", 32'(dut_start), 32'(1));
    chk("abort_cycles", 32'(cycles), 32'(0));
    chk("abort_mem_wr_en", 32'(mem_wr_en), 32'(0));
    @(negedge CLK);
    sb_q.push_back(mk_exp(1, 0, 0, 0, 20, 285));
    start = 1'b0;
    wait_done(400);

    // Halt held high through CLEAR and LOAD is ignored.
    halt_force = 1'b1;
    begin_run(mk_exp(1, 0, 0, 0, 20, 285), 20, 1'b1, 1'b0);
    n = 0;
    while (edge_cnt < 258 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("early_halt_still_loading", 32'(dut_start), 32'(1));
    halt_force = 1'b0;
    wait_done(400);

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
